// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants, state encoding and frame builder for the memory access protocol
package mem_access_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h0F;
    localparam logic [7:0] CMD_READ     = 8'hFF;
    localparam int         ADDR_WIDTH   = 16;
    localparam int         WR_FRAME_LEN = 8;
    localparam int         RD_FRAME_LEN = 3;
    localparam int         RD_RESP_LEN  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RX,
        ST_RESP
    } state_t;

    // Byte 0 of the frame sits in bits [7:0]; later bytes follow upward.
    function automatic logic [63:0] build_frame(
        input logic                  write,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [3:0]            we,
        input logic [31:0]           wdata
    );
        logic [63:0] f;
        if (write) begin
            f = {wdata, 4'b0000, we, addr, CMD_WRITE};
        end else begin
            f = {40'd0, addr, CMD_READ};
        end
        return f;
    endfunction

endpackage

// File: rtl/mem_access_timer.sv
// rtl/mem_access_timer.sv - loadable down-counter that holds at zero and flags expiry
module mem_access_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mem_access_host.sv
// rtl/mem_access_host.sv - host initiator serialising read/write requests onto a byte-wide UART path
module mem_access_host
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_we,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic                  TX_enable,
    output logic [7:0]            TX_data,
    input  logic                  tx_done,
    input  logic [7:0]            RX_data,
    input  logic                  rx_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state, state_next;
    logic [63:0] frame, frame_next;
    logic        is_write, is_write_next;
    logic [2:0]  idx, idx_next;
    logic [1:0]  rx_cnt, rx_cnt_next;
    logic [23:0] rx_shift, rx_shift_next;
    logic        tx_enable_next;
    logic [7:0]  tx_data_next;
    logic        resp_valid_next;
    logic        resp_err_next;
    logic [31:0] resp_rdata_next;
    logic        tmr_load;
    logic        tmr_expired;
    logic [2:0]  last_idx;
    logic [63:0] new_frame;

    function automatic logic [7:0] frame_byte(input logic [63:0] f, input logic [2:0] i);
        return 8'(f >> {i, 3'b000});
    endfunction

    assign new_frame = build_frame(req_write, req_addr, req_we, req_wdata);
    assign last_idx  = is_write ? 3'(WR_FRAME_LEN - 1) : 3'(RD_FRAME_LEN - 1);

    mem_access_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_value(TW'(TIMEOUT_CYCLES)),
        .en        (state == ST_WAIT_RX),
        .expired   (tmr_expired)
    );

    always_comb begin
        state_next      = state;
        frame_next      = frame;
        is_write_next   = is_write;
        idx_next        = idx;
        rx_cnt_next     = rx_cnt;
        rx_shift_next   = rx_shift;
        tx_enable_next  = TX_enable;
        tx_data_next    = TX_data;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = 32'd0;
        tmr_load        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next     = ST_SEND;
                    frame_next     = new_frame;
                    is_write_next  = req_write;
                    idx_next       = 3'd0;
                    tx_enable_next = 1'b1;
                    tx_data_next   = new_frame[7:0];
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    if (idx == last_idx) begin
                        tx_enable_next = 1'b0;
                        tx_data_next   = 8'd0;
                        if (is_write) begin
                            state_next      = ST_RESP;
                            resp_valid_next = 1'b1;
                        end else begin
                            state_next    = ST_WAIT_RX;
                            rx_cnt_next   = 2'd0;
                            rx_shift_next = 24'd0;
                            tmr_load      = 1'b1;
                        end
                    end else begin
                        idx_next     = idx + 3'd1;
                        tx_data_next = frame_byte(frame, idx + 3'd1);
                    end
                end
            end
            ST_WAIT_RX: begin
                // A fourth byte arriving on the expiry cycle still counts as a good response.
                if (rx_done) begin
                    rx_shift_next = {RX_data, rx_shift[23:8]};
                    rx_cnt_next   = rx_cnt + 2'd1;
                    if (rx_cnt == 2'(RD_RESP_LEN - 1)) begin
                        state_next      = ST_RESP;
                        resp_valid_next = 1'b1;
                        resp_rdata_next = {RX_data, rx_shift};
                    end
                end else if (tmr_expired) begin
                    state_next      = ST_RESP;
                    resp_valid_next = 1'b1;
                    resp_err_next   = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            frame      <= 64'd0;
            is_write   <= 1'b0;
            idx        <= 3'd0;
            rx_cnt     <= 2'd0;
            rx_shift   <= 24'd0;
            TX_enable  <= 1'b0;
            TX_data    <= 8'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            req_ready  <= 1'b1;
        end else begin
            state      <= state_next;
            frame      <= frame_next;
            is_write   <= is_write_next;
            idx        <= idx_next;
            rx_cnt     <= rx_cnt_next;
            rx_shift   <= rx_shift_next;
            TX_enable  <= tx_enable_next;
            TX_data    <= tx_data_next;
            resp_valid <= resp_valid_next;
            resp_err   <= resp_err_next;
            resp_rdata <= resp_rdata_next;
            req_ready  <= (state_next == ST_IDLE);
        end
    end

endmodule
